pkt_framer_ctrl: RTL and testbench

PKT_FRAMER_CTRL -- requirements
Module: pkt_framer_ctrl

---
 rtl/pkt_framer_ctrl_if.sv | 22 ++
 rtl/pkt_framer_ctrl.sv | 148 ++++++++++++++
 tb/tb_pkt_framer_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pkt_framer_ctrl_if.sv
// Byte-stream interface between the packet source and the symbol framer.
// Carries the upstream handshake plus the registered symbol/data/enable to MuxCtrl.
interface pkt_framer_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_dllp;
    logic       in_ready;
    logic [3:0] S;
    logic [7:0] data;
    logic       enb;

    modport master (
        output in_valid, in_data, in_last, in_dllp,
        input  in_ready, S, data, enb
    );

    modport slave (
        input  in_valid, in_data, in_last, in_dllp,
        output in_ready, S, data, enb
    );
endinterface

// File: rtl/pkt_framer_ctrl.sv
// Packet framer: wraps payload bytes as START/DATA/END symbols for MuxCtrl, IDL when quiet.
// Latency: S/data/enb registered one cycle after the accepting edge; in_ready from state only.
// Backpressure: bytes accepted only in DATA; an underrun cycle drops enb. FRAMER_SKP_EN adds SKP ordered sets.
module pkt_framer_ctrl #(
    parameter int SKP_INTERVAL = 16
) (
    input  logic               clk,
    input  logic               reset_L,
    pkt_framer_ctrl_if.slave   bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_END     = 3'd3;
`ifdef FRAMER_SKP_EN
    localparam logic [2:0] ST_SKP_COM = 3'd4;
    localparam logic [2:0] ST_SKP1    = 3'd5;
    localparam logic [2:0] ST_SKP2    = 3'd6;
    localparam logic [2:0] ST_SKP3    = 3'd7;
    localparam logic [3:0] SYM_COM    = 4'b0010;
    localparam logic [3:0] SYM_SKP    = 4'b0011;
`endif

    localparam logic [3:0] SYM_DATA   = 4'b0000;
    localparam logic [3:0] SYM_STP    = 4'b0100;
    localparam logic [3:0] SYM_SDP    = 4'b0101;
    localparam logic [3:0] SYM_END    = 4'b0110;
    localparam logic [3:0] SYM_IDL    = 4'b1001;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       dllp_q;
    logic [3:0] s_q;
    logic [3:0] s_nxt;
    logic [7:0] data_q;
    logic [7:0] data_nxt;
    logic       enb_q;
    logic       enb_nxt;

`ifdef FRAMER_SKP_EN
    localparam logic [7:0] SKP_LAST = 8'(SKP_INTERVAL - 1);

    logic [7:0] skp_cnt;
    logic       skp_pend;

    // Counter saturates at SKP_LAST; the ordered set's last symbol restarts the interval.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            skp_cnt  <= 8'd0;
            skp_pend <= 1'b0;
        end else if (state == ST_SKP3) begin
            skp_cnt  <= 8'd0;
            skp_pend <= 1'b0;
        end else if (skp_cnt != SKP_LAST) begin
            skp_cnt <= skp_cnt + 8'd1;
            if (skp_cnt + 8'd1 == SKP_LAST)
                skp_pend <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        data_nxt  = data_q;
        enb_nxt   = 1'b1;
        case (state)
            ST_IDLE: begin
                s_nxt = SYM_IDL;
`ifdef FRAMER_SKP_EN
                if (skp_pend)
                    state_nxt = ST_SKP_COM;
                else if (bus.in_valid)
                    state_nxt = ST_START;
`else
                if (bus.in_valid)
                    state_nxt = ST_START;
`endif
            end
            ST_START: begin
                s_nxt     = dllp_q ? SYM_SDP : SYM_STP;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                // Underrun: hold S/data, only enb drops.
                if (bus.in_valid) begin
                    s_nxt    = SYM_DATA;
                    data_nxt = bus.in_data;
                    if (bus.in_last)
                        state_nxt = ST_END;
                end else begin
                    enb_nxt = 1'b0;
                end
            end
            ST_END: begin
                s_nxt     = SYM_END;
                state_nxt = ST_IDLE;
            end
`ifdef FRAMER_SKP_EN
            ST_SKP_COM: begin
                s_nxt     = SYM_COM;
                state_nxt = ST_SKP1;
            end
            ST_SKP1: begin
                s_nxt     = SYM_SKP;
                state_nxt = ST_SKP2;
            end
            ST_SKP2: begin
                s_nxt     = SYM_SKP;
                state_nxt = ST_SKP3;
            end
            ST_SKP3: begin
                s_nxt     = SYM_SKP;
                state_nxt = ST_IDLE;
            end
`endif
            default: begin
                s_nxt     = SYM_IDL;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= ST_IDLE;
            dllp_q <= 1'b0;
            s_q    <= SYM_IDL;
            data_q <= 8'h00;
            enb_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            s_q    <= s_nxt;
            data_q <= data_nxt;
            enb_q  <= enb_nxt;
            // Packet type is captured only on the IDLE->START transition.
            if (state == ST_IDLE && state_nxt == ST_START)
                dllp_q <= bus.in_dllp;
        end
    end

    assign bus.in_ready = (state == ST_DATA);
    assign bus.S        = s_q;
    assign bus.data     = data_q;
    assign bus.enb      = enb_q;

endmodule

// File: tb/tb_pkt_framer_ctrl.sv
// Directed, table-driven bench for pkt_framer_ctrl; SKP checks follow FRAMER_SKP_EN.
module tb_pkt_framer_ctrl;

    logic clk     = 1'b0;
    logic reset_L = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pkt_framer_ctrl_if bus ();

    pkt_framer_ctrl #(.SKP_INTERVAL(16)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       last;
        logic       dllp;
        logic       rdy;   // in_ready expected before the edge
        logic [3:0] s;     // outputs expected after the edge
        logic [7:0] dat;
        logic       enb;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic t);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_dllp  = t;
    endtask

    // Leaves reset released at a falling edge; the next rising edge is edge 0.
    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        chk("rst_S",     32'(bus.S),        32'h9);
        chk("rst_data",  32'(bus.data),     32'h00);
        chk("rst_enb",   32'(bus.enb),      32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

`ifdef FRAMER_SKP_EN
    function automatic logic [3:0] skp_exp(input int e);
        if (e == 16 || e == 36) return 4'b0010;
        if ((e >= 17 && e <= 19) || (e >= 37 && e <= 39)) return 4'b0011;
        return 4'b1001;
    endfunction
`endif

    initial begin
        // TLP A1 B2 C3, DLLP with underrun (in_last ignored while invalid), then back-to-back TLP 7C
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 4'b1001, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 4'b0000, 8'hA1, 1'b1};
        tbl[3]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 4'b0000, 8'hB2, 1'b1};
        tbl[4]  = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 4'b0000, 8'hC3, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0110, 8'hC3, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b1001, 8'hC3, 1'b1};
        tbl[7]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 4'b1001, 8'hC3, 1'b1};
        tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 4'b0101, 8'hC3, 1'b1};
        tbl[9]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h5A, 1'b1};
        tbl[10] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 4'b0000, 8'h5A, 1'b0};
        tbl[11] = '{1'b1, 8'h6B, 1'b1, 1'b0, 1'b1, 4'b0000, 8'h6B, 1'b1};
        tbl[12] = '{1'b1, 8'h7C, 1'b0, 1'b0, 1'b0, 4'b0110, 8'h6B, 1'b1};
        tbl[13] = '{1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 4'b1001, 8'h6B, 1'b1};
        tbl[14] = '{1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 4'b0100, 8'h6B, 1'b1};
        tbl[15] = '{1'b1, 8'h7C, 1'b1, 1'b0, 1'b1, 4'b0000, 8'h7C, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0110, 8'h7C, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'b1001, 8'h7C, 1'b1};

        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;

        // Idle after reset
        do_reset();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("idle%0d_ready", c), 32'(bus.in_ready), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("idle%0d_S", c),   32'(bus.S),   32'h9);
            chk($sformatf("idle%0d_enb", c), 32'(bus.enb), 32'h1);
        end

        // Packet vectors
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].vld, tbl[i].din, tbl[i].last, tbl[i].dllp);
            chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_S", i),    32'(bus.S),    32'(tbl[i].s));
            chk($sformatf("v%0d_data", i), 32'(bus.data), 32'(tbl[i].dat));
            chk($sformatf("v%0d_enb", i),  32'(bus.enb),  32'(tbl[i].enb));
        end

        // Reset pulsed mid-DATA
        do_reset();
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_pre_S",    32'(bus.S),    32'h0);
        chk("mid_pre_data", 32'(bus.data), 32'h11);
        #2;
        reset_L = 1'b0;
        #1;
        chk("mid_rst_S",     32'(bus.S),        32'h9);
        chk("mid_rst_data",  32'(bus.data),     32'h00);
        chk("mid_rst_enb",   32'(bus.enb),      32'h0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_post%0d_S", c),     32'(bus.S),        32'h9);
            chk($sformatf("mid_post%0d_enb", c),   32'(bus.enb),      32'h1);
            chk($sformatf("mid_post%0d_ready", c), 32'(bus.in_ready), 32'h0);
        end

`ifdef FRAMER_SKP_EN
        // Periodic SKP ordered sets while idle
        do_reset();
        for (int e = 0; e <= 40; e++) begin
            @(posedge clk); #1;
            chk($sformatf("skp_idle_e%0d_S", e), 32'(bus.S), 32'(skp_exp(e)));
        end

        // in_valid raised in the cycle the SKP becomes due: START waits for SKP3
        do_reset();
        for (int e = 0; e <= 23; e++) begin
            if (e == 15) drive(1'b1, 8'h44, 1'b1, 1'b0);
            if (e == 23) drive(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("skp_pkt_e%0d_ready", e), 32'(bus.in_ready), (e == 22) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
            if (e <= 15 || e == 20)
                chk($sformatf("skp_pkt_e%0d_S", e), 32'(bus.S), 32'h9);
            else if (e == 16)
                chk($sformatf("skp_pkt_e%0d_S", e), 32'(bus.S), 32'h2);
            else if (e <= 19)
                chk($sformatf("skp_pkt_e%0d_S", e), 32'(bus.S), 32'h3);
            else if (e == 21)
                chk($sformatf("skp_pkt_e%0d_S", e), 32'(bus.S), 32'h4);
            else if (e == 22) begin
                chk($sformatf("skp_pkt_e%0d_S", e),    32'(bus.S),    32'h0);
                chk($sformatf("skp_pkt_e%0d_data", e), 32'(bus.data), 32'h44);
            end else
                chk($sformatf("skp_pkt_e%0d_S", e), 32'(bus.S), 32'h6);
        end
`else
        // No SKP symbols ever appear without the feature
        begin
            int bad;
            bad = 0;
            do_reset();
            for (int e = 0; e < 300; e++) begin
                @(posedge clk); #1;
                if (bus.S == 4'b0010 || bus.S == 4'b0011 || bus.S !== 4'b1001 || bus.enb !== 1'b1)
                    bad++;
            end
            chk("noskp_bad_cycles", 32'(bad), 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
